// File: rtl/mac_tx_bit_serializer.sv
// MAC transmit bit serializer: byte handshake in, one-hot PLS_DATA.request primitives out.
// Optional carrier extension to slot time is built when MAC_CARRIER_EXT_EN is defined.
module mac_tx_bit_serializer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_BITS       = 512,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [4:0] pls_data_request,
  output logic       tx_busy,
  output logic       underrun
);

  localparam int PRE_BITS = 8 * PREAMBLE_BYTES;
  localparam int IDX_W    = $clog2(PRE_BITS);

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_BITS - 1);
  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(7);
  localparam logic [7:0]       SFD_PATTERN = 8'hD5;

  localparam logic [6:0] ST_IDLE     = 7'b0000001;
  localparam logic [6:0] ST_PREAMBLE = 7'b0000010;
  localparam logic [6:0] ST_SFD      = 7'b0000100;
  localparam logic [6:0] ST_DATA     = 7'b0001000;
  localparam logic [6:0] ST_ABORT    = 7'b0010000;
  localparam logic [6:0] ST_COMPLETE = 7'b0100000;
`ifdef MAC_CARRIER_EXT_EN
  localparam logic [6:0] ST_EXT      = 7'b1000000;
  localparam logic [CNT_W-1:0] SLOT_BITS = CNT_W'(MIN_BITS);
`endif

  localparam logic [4:0] REQ_NONE     = 5'b00000;
  localparam logic [4:0] REQ_ZERO     = 5'b00001;
  localparam logic [4:0] REQ_ONE      = 5'b00010;
  localparam logic [4:0] REQ_EXT_ERR  = 5'b00100;
  localparam logic [4:0] REQ_EXTEND   = 5'b01000;
  localparam logic [4:0] REQ_COMPLETE = 5'b10000;

  function automatic logic [4:0] bit_req(input logic b);
    return b ? REQ_ONE : REQ_ZERO;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [6:0]       state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [6:0]       shift_r, shift_s;
  logic             last_r, last_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [4:0]       req_r, req_s;
  logic             busy_r;
  logic             underrun_r, underrun_s;
  logic             hold_valid_r, hold_valid_s;
  logic [7:0]       hold_data_r;
  logic             hold_last_r;
  logic             ready_r;
  logic             drain_r, drain_s;
  logic             fill_s, keep_s, load_s, abort_clr_s, next_byte_s;

  assign tx_ready         = ready_r;
  assign pls_data_request = req_r;
  assign tx_busy          = busy_r;
  assign underrun         = underrun_r;

  // After an abort, bytes are swallowed up to and including the one flagged last.
  assign fill_s = tx_valid && ready_r;
  assign keep_s = fill_s && !drain_r && (state_r != ST_ABORT);

  // Next-state logic; the request computed here is what the register shows next cycle.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    shift_s     = shift_r;
    last_s      = last_r;
    cnt_s       = cnt_r;
    req_s       = REQ_NONE;
    underrun_s  = 1'b0;
    load_s      = 1'b0;
    abort_clr_s = 1'b0;
    next_byte_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_valid_r) begin
          state_s = ST_PREAMBLE;
          idx_s   = IDX_ZERO;
          cnt_s   = {CNT_W{1'b0}};
          req_s   = REQ_ONE;
        end else begin
          req_s = REQ_NONE;
        end
      end
      ST_PREAMBLE: begin
        if (idx_r == PRE_LAST) begin
          state_s = ST_SFD;
          idx_s   = IDX_ZERO;
          req_s   = bit_req(SFD_PATTERN[0]);
        end else begin
          idx_s = idx_r + IDX_ONE;
          req_s = bit_req(~idx_s[0]);
        end
      end
      ST_SFD: begin
        if (idx_r == BYTE_LAST) begin
          next_byte_s = 1'b1;
        end else begin
          idx_s = idx_r + IDX_ONE;
          req_s = bit_req(SFD_PATTERN[idx_s[2:0]]);
        end
      end
      ST_DATA: begin
        if (idx_r != BYTE_LAST) begin
          idx_s   = idx_r + IDX_ONE;
          req_s   = bit_req(shift_r[0]);
          shift_s = {1'b0, shift_r[6:1]};
          cnt_s   = sat_inc(cnt_r);
        end else if (!last_r) begin
          next_byte_s = 1'b1;
`ifdef MAC_CARRIER_EXT_EN
        end else if (cnt_r < SLOT_BITS) begin
          state_s = ST_EXT;
          req_s   = REQ_EXTEND;
          cnt_s   = sat_inc(cnt_r);
`endif
        end else begin
          state_s = ST_COMPLETE;
          req_s   = REQ_COMPLETE;
        end
      end
`ifdef MAC_CARRIER_EXT_EN
      ST_EXT: begin
        if (cnt_r >= SLOT_BITS) begin
          state_s = ST_COMPLETE;
          req_s   = REQ_COMPLETE;
        end else begin
          req_s = REQ_EXTEND;
          cnt_s = sat_inc(cnt_r);
        end
      end
`endif
      ST_ABORT: begin
        abort_clr_s = 1'b1;
        state_s     = ST_COMPLETE;
        req_s       = REQ_COMPLETE;
      end
      ST_COMPLETE: begin
        state_s = ST_IDLE;
        req_s   = REQ_NONE;
      end
      default: begin
        state_s = ST_IDLE;
        req_s   = REQ_NONE;
      end
    endcase

    // Shared byte-boundary step: continue seamlessly from hold, or abort on underrun.
    if (next_byte_s && hold_valid_r) begin
      load_s  = 1'b1;
      state_s = ST_DATA;
      idx_s   = IDX_ZERO;
      shift_s = hold_data_r[7:1];
      last_s  = hold_last_r;
      req_s   = bit_req(hold_data_r[0]);
      cnt_s   = sat_inc(cnt_r);
    end else if (next_byte_s) begin
      state_s    = ST_ABORT;
      req_s      = REQ_EXT_ERR;
      underrun_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Holding register occupancy and post-abort drain tracking.
  always_comb begin
    if (load_s || abort_clr_s) begin
      hold_valid_s = 1'b0;
    end else if (keep_s) begin
      hold_valid_s = 1'b1;
    end else begin
      hold_valid_s = hold_valid_r;
    end
    if (state_r == ST_ABORT) begin
      drain_s = !((hold_valid_r && hold_last_r) || (fill_s && tx_last));
    end else if (drain_r && fill_s && tx_last) begin
      drain_s = 1'b0;
    end else begin
      drain_s = drain_r;
    end
  end

  // Holding register and handshake state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'h00;
      hold_last_r  <= 1'b0;
      ready_r      <= 1'b1;
      drain_r      <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_s;
      ready_r      <= ~hold_valid_s;
      drain_r      <= drain_s;
      if (keep_s) begin
        hold_data_r <= tx_data;
        hold_last_r <= tx_last;
      end
    end
  end

  // FSM, shifter, frame counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= IDX_ZERO;
      shift_r    <= 7'h00;
      last_r     <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      req_r      <= REQ_NONE;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      shift_r    <= shift_s;
      last_r     <= last_s;
      cnt_r      <= cnt_s;
      req_r      <= req_s;
      busy_r     <= (state_s != ST_IDLE);
      underrun_r <= underrun_s;
    end
  end

endmodule

// File: tb/tb_mac_tx_bit_serializer.sv
// Scoreboard bench for mac_tx_bit_serializer: expected request streams are queued per frame
// and compared against the captured pls_data_request stream.
module tb_mac_tx_bit_serializer;

  localparam logic [4:0] R_NONE = 5'b00000;
  localparam logic [4:0] R_ZERO = 5'b00001;
  localparam logic [4:0] R_ONE  = 5'b00010;
  localparam logic [4:0] R_ERR  = 5'b00100;
  localparam logic [4:0] R_EXT  = 5'b01000;
  localparam logic [4:0] R_DONE = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [4:0] pls;
  logic       tx_busy;
  logic       underrun;

  int checks = 0;
  int passed = 0;

  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int   cap_base = 0;
  logic cap_en = 1'b0;
  logic in_frame = 1'b0;
  logic rdy_prev = 1'b1;
  int   rdy_rises = 0;
  int   und_cnt = 0;
  int   und_err_cnt = 0;

  mac_tx_bit_serializer dut (
    .clk              (clk),
    .reset            (reset),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_last          (tx_last),
    .tx_ready         (tx_ready),
    .pls_data_request (pls),
    .tx_busy          (tx_busy),
    .underrun         (underrun)
  );

  always #5 clk = ~clk;

  // Output monitor: records the request stream from the first non-idle request onward.
  always @(negedge clk) begin
    if (cap_en) begin
      if (in_frame || (pls !== R_NONE)) begin
        obs_q.push_back(pls);
        in_frame <= 1'b1;
      end
    end else begin
      in_frame <= 1'b0;
    end
    if (tx_ready && !rdy_prev) rdy_rises <= rdy_rises + 1;
    rdy_prev <= tx_ready;
    if (underrun) begin
      und_cnt <= und_cnt + 1;
      if (pls === R_ERR) und_err_cnt <= und_err_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, checks);
    $fatal(1);
  end

  task automatic push_pre_sfd();
    logic [7:0] sfd;
    sfd = 8'hD5;
    for (int i = 0; i < 56; i++) exp_q.push_back((i % 2 == 0) ? R_ONE : R_ZERO);
    for (int i = 0; i < 8; i++) exp_q.push_back(sfd[i] ? R_ONE : R_ZERO);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i] ? R_ONE : R_ZERO);
  endtask

  task automatic push_tail(input int nbits);
`ifdef MAC_CARRIER_EXT_EN
    for (int i = nbits; i < 512; i++) exp_q.push_back(R_EXT);
`endif
    exp_q.push_back(R_DONE);
    exp_q.push_back(R_NONE);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l, output logic ok);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic start_cap();
    @(posedge clk);
    exp_q.delete();
    cap_base = obs_q.size();
    cap_en   = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_cap();
    @(posedge clk);
    cap_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 5000; i++) begin
      if (obs_q.size() - cap_base >= n) break;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pls !== R_NONE) $display("FAIL reset_pls: got %b want %b", pls, R_NONE); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", tx_ready); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one_byte();
    logic ok;
    int bad;
    start_cap();
    push_pre_sfd(); push_byte(8'hA5); push_tail(8);
    send_byte(8'hA5, 1'b1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL one_byte_accept: got %b want 1", ok); else passed++;
    checks++; if (pls !== R_NONE) $display("FAIL one_byte_pre_latency: got %b want %b", pls, R_NONE); else passed++;
    @(negedge clk);
    checks++; if (pls !== R_ONE) $display("FAIL one_byte_first_preamble: got %b want %b", pls, R_ONE); else passed++;
    checks++; if (tx_busy !== 1'b1) $display("FAIL one_byte_busy: got %b want 1", tx_busy); else passed++;
    wait_obs(exp_q.size());
    checks++;
    if (obs_q.size() - cap_base < exp_q.size())
      $display("FAIL one_byte_len: got %0d requests want %0d", obs_q.size() - cap_base, exp_q.size());
    else passed++;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((cap_base + i < obs_q.size()) && (obs_q[cap_base + i] !== exp_q[i])) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) $display("FAIL one_byte_stream: at %0d got %b want %b", bad, obs_q[cap_base + bad], exp_q[bad]);
    else passed++;
    stop_cap();
    checks++; if (tx_busy !== 1'b0) $display("FAIL one_byte_idle_busy: got %b want 0", tx_busy); else passed++;
  endtask

  task automatic test_stream64();
    logic ok;
    logic [7:0] d;
    int bad;
    int r0;
    int nok;
    start_cap();
    r0 = rdy_rises;
    nok = 0;
    push_pre_sfd();
    for (int i = 0; i < 64; i++) begin d = 8'(i * 37 + 5); push_byte(d); end
    push_tail(512);
    for (int i = 0; i < 64; i++) begin
      d = 8'(i * 37 + 5);
      send_byte(d, (i == 63), ok);
      if (!ok) nok++;
      tx_valid = 1'b1;
    end
    tx_valid = 1'b0;
    checks++; if (nok != 0) $display("FAIL stream64_accept: got %0d refused want 0", nok); else passed++;
    wait_obs(exp_q.size());
    checks++;
    if (obs_q.size() - cap_base < exp_q.size())
      $display("FAIL stream64_len: got %0d requests want %0d", obs_q.size() - cap_base, exp_q.size());
    else passed++;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((cap_base + i < obs_q.size()) && (obs_q[cap_base + i] !== exp_q[i])) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) $display("FAIL stream64_stream: at %0d got %b want %b", bad, obs_q[cap_base + bad], exp_q[bad]);
    else passed++;
    stop_cap();
    checks++; if (rdy_rises - r0 != 64) $display("FAIL stream64_ready_pulses: got %0d want 64", rdy_rises - r0); else passed++;
  endtask

  task automatic test_late_byte();
    logic ok;
    int bad;
    int u0;
    int e0;
    int nz;
    start_cap();
    u0 = und_cnt;
    e0 = und_err_cnt;
    push_pre_sfd(); push_byte(8'h01);
    exp_q.push_back(R_ERR); exp_q.push_back(R_DONE); exp_q.push_back(R_NONE);
    send_byte(8'h01, 1'b0, ok);
    for (int i = 0; i < 300; i++) begin
      if (und_cnt != u0) break;
      @(posedge clk);
    end
    @(negedge clk);
    send_byte(8'h80, 1'b1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL late_drain_accept: got %b want 1", ok); else passed++;
    wait_obs(exp_q.size());
    checks++;
    if (obs_q.size() - cap_base < exp_q.size())
      $display("FAIL late_len: got %0d requests want %0d", obs_q.size() - cap_base, exp_q.size());
    else passed++;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((cap_base + i < obs_q.size()) && (obs_q[cap_base + i] !== exp_q[i])) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) $display("FAIL late_stream: at %0d got %b want %b", bad, obs_q[cap_base + bad], exp_q[bad]);
    else passed++;
    stop_cap();
    checks++; if (und_cnt - u0 != 1) $display("FAIL late_underrun_pulses: got %0d want 1", und_cnt - u0); else passed++;
    checks++; if (und_err_cnt - e0 != 1) $display("FAIL late_underrun_align: got %0d want 1", und_err_cnt - e0); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL late_busy: got %b want 0", tx_busy); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL late_ready: got %b want 1", tx_ready); else passed++;
    nz = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (pls !== R_NONE) nz++;
    end
    checks++; if (nz != 0) $display("FAIL late_discarded: got %0d active cycles want 0", nz); else passed++;
  endtask

  task automatic test_back_to_back();
    logic ok1;
    logic ok2;
    int bad;
    start_cap();
    push_pre_sfd(); push_byte(8'h3C); push_tail(8);
    push_pre_sfd(); push_byte(8'h5A); push_tail(8);
    send_byte(8'h3C, 1'b1, ok1);
    send_byte(8'h5A, 1'b1, ok2);
    checks++; if ((ok1 & ok2) !== 1'b1) $display("FAIL b2b_accept: got %b%b want 11", ok1, ok2); else passed++;
    wait_obs(exp_q.size());
    checks++;
    if (obs_q.size() - cap_base < exp_q.size())
      $display("FAIL b2b_len: got %0d requests want %0d", obs_q.size() - cap_base, exp_q.size());
    else passed++;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((cap_base + i < obs_q.size()) && (obs_q[cap_base + i] !== exp_q[i])) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) $display("FAIL b2b_stream: at %0d got %b want %b", bad, obs_q[cap_base + bad], exp_q[bad]);
    else passed++;
    stop_cap();
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    int found;
    int bad;
    send_byte(8'hA5, 1'b1, ok);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (pls !== R_NONE) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (found != 1) $display("FAIL midrst_start: got %0d want 1", found); else passed++;
    repeat (67) @(negedge clk);
    checks++; if (pls !== R_ZERO) $display("FAIL midrst_bit3: got %b want %b", pls, R_ZERO); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (pls !== R_NONE) $display("FAIL midrst_pls: got %b want %b", pls, R_NONE); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", tx_ready); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", tx_busy); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_cap();
    push_pre_sfd(); push_byte(8'hC3); push_tail(8);
    send_byte(8'hC3, 1'b1, ok);
    wait_obs(exp_q.size());
    checks++;
    if (obs_q.size() - cap_base < exp_q.size())
      $display("FAIL midrst_len: got %0d requests want %0d", obs_q.size() - cap_base, exp_q.size());
    else passed++;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((cap_base + i < obs_q.size()) && (obs_q[cap_base + i] !== exp_q[i])) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) $display("FAIL midrst_stream: at %0d got %b want %b", bad, obs_q[cap_base + bad], exp_q[bad]);
    else passed++;
    stop_cap();
  endtask

  task automatic test_fill_empty();
    logic ok;
    logic [7:0] bytes [4];
    int bad;
    int held;
    bytes[0] = 8'h0F; bytes[1] = 8'hF0; bytes[2] = 8'h96; bytes[3] = 8'h69;
    start_cap();
    held = 0;
    push_pre_sfd();
    for (int i = 0; i < 4; i++) push_byte(bytes[i]);
    push_tail(32);
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], (i == 3), ok);
      if (ok && (tx_ready === 1'b0)) held++;
      tx_valid = 1'b1;
    end
    tx_valid = 1'b0;
    checks++; if (held != 4) $display("FAIL fill_hold_full: got %0d want 4", held); else passed++;
    wait_obs(exp_q.size());
    checks++;
    if (obs_q.size() - cap_base < exp_q.size())
      $display("FAIL fill_len: got %0d requests want %0d", obs_q.size() - cap_base, exp_q.size());
    else passed++;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((cap_base + i < obs_q.size()) && (obs_q[cap_base + i] !== exp_q[i])) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) $display("FAIL fill_stream: at %0d got %b want %b", bad, obs_q[cap_base + bad], exp_q[bad]);
    else passed++;
    stop_cap();
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_stream64();
    test_late_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_fill_empty();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_bit_serializer.md
Name: mac_tx_bit_serializer

Overview:
- MAC transmit stage sitting directly upstream of the GMII transmit layer (capa1v2).
- Accepts frame bytes over a valid/ready handshake and emits one PLS_DATA.request primitive per clock on a one-hot pls_data_request bus: preamble, SFD, then data bits LSB first.
- With the optional feature compiled in, adds carrier extension up to slot time, then closes the frame with DATA_COMPLETE.

Parameters:
- PREAMBLE_BYTES, 7, number of 0x55 preamble bytes sent before the SFD.
- MIN_BITS, 512, slot time in bits counted from the first data bit; used for carrier extension.
- CNT_W, 16, width of the frame bit counter. It saturates at all-ones.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  8  frame byte.
- tx_valid  input  1  tx_data/tx_last valid.
- tx_last  input  1  marks the final byte of the frame.
- tx_ready  output  1  holding register empty; a byte is accepted when tx_valid&&tx_ready at a rising edge.
- pls_data_request  output  5  one-hot request: [0]=ZERO, [1]=ONE, [2]=EXTEND_ERROR, [3]=EXTEND, [4]=DATA_COMPLETE, 5'b00000=no request.
- tx_busy  output  1  high in every state except IDLE.
- underrun  output  1  one-cycle pulse when a frame is aborted for lack of data.

Behaviour:
- Reset state (asserted low, takes effect immediately):
  - pls_data_request=0, tx_busy=0, underrun=0.
  - tx_ready=1; holding register empty; state IDLE.
- Holding register (1 byte plus last flag):
  - tx_ready = ~hold_valid, registered.
  - Fills on handshake; empties when the shifter loads from it.
  - A fill and an empty in the same cycle leave it empty; tx_ready rises the next cycle.
- All outputs are registered. Each state's request appears on pls_data_request the cycle after entry.
- FSM, one-hot states IDLE, PREAMBLE, SFD, DATA, EXT, ABORT, COMPLETE:
  - IDLE: output 0. Go to PREAMBLE when hold_valid=1. The first preamble bit appears 1 cycle after the first handshake edge when entering from reset-idle.
  - PREAMBLE: 8*PREAMBLE_BYTES cycles. Bit counter even -> ONE, odd -> ZERO (sequence 1,0,1,0,...).
  - SFD: 8 cycles in order 1,0,1,0,1,0,1,1.
    - On the last SFD cycle, load the shifter from hold.
    - If hold is empty at that point, go to ABORT.
  - DATA: emit shifter bit 0 each cycle, shift right, 8 cycles per byte. Frame bit counter increments each DATA cycle.
    - At bit 7 of a non-last byte with hold_valid=1: load the next byte, stay in DATA. There is no gap between bytes.
    - At bit 7 of a non-last byte with hold empty: go to ABORT.
    - At bit 7 of the last byte: go to EXT if the feature is enabled and the bit count is below MIN_BITS, else go to COMPLETE.
  - EXT: emit EXTEND; the counter keeps incrementing. Go to COMPLETE when the count reaches MIN_BITS.
  - ABORT: one cycle EXTEND_ERROR and an underrun pulse. Discard any held bytes through tx_last; hold stays ready-draining. Then go to COMPLETE.
  - COMPLETE: one cycle DATA_COMPLETE, then IDLE.
- Inter-frame spacing: IDLE lasts at least 1 cycle (output 0) between frames, even if hold is already full.
- Reset mid-frame: outputs return immediately to their reset values; the partial frame is lost and no DATA_COMPLETE is sent.
- Counter: CNT_W bits, cleared on entry to PREAMBLE, saturating.

Optional Feature:
- Macro: MAC_CARRIER_EXT_EN.
- Defined: the EXT state exists; short frames are padded with EXTEND to MIN_BITS data+extension bits before DATA_COMPLETE.
- Undefined: the EXT state is not built; the last data bit is always followed directly by COMPLETE; MIN_BITS is unused.

Test Plan:
- Reset, then a one-byte frame 0xA5 with tx_last=1:
  - Outputs: 56 alternating ONE/ZERO starting with ONE, then SFD 1,0,1,0,1,0,1,1, then data ONE,ZERO,ONE,ZERO,ZERO,ONE,ZERO,ONE.
  - With MAC_CARRIER_EXT_EN: 504 EXTEND cycles, then one DATA_COMPLETE, then 00000.
  - Without the macro: DATA_COMPLETE immediately after the 8th data bit.
- 64-byte frame streamed with tx_valid held high: 512 contiguous data requests, tx_ready pulses once per byte, no EXTEND, then DATA_COMPLETE.
- Two-byte frame 0x01, 0x80 where the second byte arrives late:
  - After 8 data bits, one EXTEND_ERROR, an underrun pulse, then DATA_COMPLETE.
  - The late byte is discarded; tx_busy falls.
- Back-to-back frames with the next first byte already held: exactly one 00000 cycle between DATA_COMPLETE and the next preamble ONE.
- Reset pulled low during DATA bit 3: pls_data_request=00000 and tx_ready=1 in the same cycle; after release, the next frame starts with a full preamble.
- Simultaneous fill/empty of hold at a byte boundary: no bit gap, and the byte sequence is preserved.
